// File: rtl/instr_decode.sv
// Decode stage: IF/ID register, field decode, bypassed 32x32 register file,
// load-use stall, branch flush, sticky HALT detection and the ID/EX register.
module instr_decode (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic [31:0] pc_added4,
    input  logic        is_taken,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        hazard_detected,
    output logic        halt_detected,
    output logic        id_valid,
    output logic [5:0]  id_opcode,
    output logic [31:0] id_rs_val,
    output logic [31:0] id_rt_val,
    output logic [31:0] id_imm,
    output logic [4:0]  id_dest,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_added4
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned NREGS = 32;

    localparam logic [OP_W-1:0] OP_XORI = 6'h0B;
    localparam logic [OP_W-1:0] OP_LDW  = 6'h0C;
    localparam logic [OP_W-1:0] OP_STW  = 6'h0D;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h0F;
    localparam logic [OP_W-1:0] OP_HALT = 6'h11;

    logic [XLEN-1:0] regs [NREGS];

    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_pc_added4;
    logic            ifid_valid;

    logic [OP_W-1:0] dec_op;
    logic [RA_W-1:0] dec_rs;
    logic [RA_W-1:0] dec_rt;
    logic [RA_W-1:0] dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic            dec_rtype;
    logic            dec_itype;
    logic            dec_rt_src;
    logic            dec_reg_write;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_halt;
    logic [RA_W-1:0] dec_dest;
    logic [XLEN-1:0] rs_val_c;
    logic [XLEN-1:0] rt_val_c;
    logic            issue_c;

    // Field decode and control generation for the word held in IF/ID.
    always_comb begin
        dec_op        = ifid_instr[31:26];
        dec_rs        = ifid_instr[25:21];
        dec_rt        = ifid_instr[20:16];
        dec_rd        = ifid_instr[15:11];
        dec_imm       = {{(XLEN-16){ifid_instr[15]}}, ifid_instr[15:0]};
        dec_rtype     = (dec_op <= OP_XORI) && !dec_op[0];
        dec_itype     = (dec_op <= OP_XORI) && dec_op[0];
        dec_mem_read  = (dec_op == OP_LDW);
        dec_mem_write = (dec_op == OP_STW);
        dec_halt      = (dec_op == OP_HALT);
        dec_rt_src    = dec_rtype || dec_mem_write || (dec_op == OP_BEQ);
        dec_reg_write = dec_rtype || dec_itype || dec_mem_read;
        dec_dest      = '0;
        if (dec_rtype) begin
            dec_dest = dec_rd;
        end else if (dec_itype || dec_mem_read) begin
            dec_dest = dec_rt;
        end
    end

    // Register reads with write-before-read bypass; R0 is hardwired to zero.
    always_comb begin
        rs_val_c = '0;
        rt_val_c = '0;
        if (dec_rs != '0) begin
            rs_val_c = (wb_en && (wb_addr == dec_rs)) ? wb_data : regs[dec_rs];
        end
        if (dec_rt != '0) begin
            rt_val_c = (wb_en && (wb_addr == dec_rt)) ? wb_data : regs[dec_rt];
        end
    end

    assign hazard_detected = ifid_valid && ex_mem_read && (ex_dest != '0) &&
                             ((ex_dest == dec_rs) || (dec_rt_src && (ex_dest == dec_rt)));

    // Once halted the held HALT must not reissue, so everything after it is a bubble.
    assign issue_c = ifid_valid && !is_taken && !hazard_detected && !halt_detected;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // IF/ID register: flush beats stall/halt hold.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            ifid_instr     <= '0;
            ifid_pc        <= '0;
            ifid_pc_added4 <= '0;
            ifid_valid     <= 1'b0;
        end else if (is_taken) begin
            ifid_valid <= 1'b0;
        end else if (!hazard_detected && !halt_detected) begin
            ifid_instr     <= instruction;
            ifid_pc        <= pc;
            ifid_pc_added4 <= pc_added4;
            ifid_valid     <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            halt_detected <= 1'b0;
        end else if (issue_c && dec_halt) begin
            halt_detected <= 1'b1;
        end
    end

    // ID/EX register: a non-issuing cycle loads an all-zero bubble.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            id_valid     <= 1'b0;
            id_opcode    <= '0;
            id_rs_val    <= '0;
            id_rt_val    <= '0;
            id_imm       <= '0;
            id_dest      <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_pc        <= '0;
            id_pc_added4 <= '0;
        end else if (issue_c) begin
            id_valid     <= 1'b1;
            id_opcode    <= dec_op;
            id_rs_val    <= rs_val_c;
            id_rt_val    <= rt_val_c;
            id_imm       <= dec_imm;
            id_dest      <= dec_dest;
            id_reg_write <= dec_reg_write;
            id_mem_read  <= dec_mem_read;
            id_mem_write <= dec_mem_write;
            id_pc        <= ifid_pc;
            id_pc_added4 <= ifid_pc_added4;
        end else begin
            id_valid     <= 1'b0;
            id_opcode    <= '0;
            id_rs_val    <= '0;
            id_rt_val    <= '0;
            id_imm       <= '0;
            id_dest      <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_pc        <= '0;
            id_pc_added4 <= '0;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: decode, bypass, load-use stall, flush, HALT, reset.
module tb_instr_decode;

    logic        clock;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_added4;
    logic        is_taken;
    logic        ex_mem_read;
    logic [4:0]  ex_dest;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hazard_detected;
    logic        halt_detected;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic [4:0]  id_dest;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic [31:0] id_pc;
    logic [31:0] id_pc_added4;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    instr_decode dut (
        .clock           (clock),
        .rst             (rst),
        .instruction     (instruction),
        .pc              (pc),
        .pc_added4       (pc_added4),
        .is_taken        (is_taken),
        .ex_mem_read     (ex_mem_read),
        .ex_dest         (ex_dest),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .hazard_detected (hazard_detected),
        .halt_detected   (halt_detected),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rs_val       (id_rs_val),
        .id_rt_val       (id_rt_val),
        .id_imm          (id_imm),
        .id_dest         (id_dest),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_pc           (id_pc),
        .id_pc_added4    (id_pc_added4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic fetch(input logic [31:0] w, input logic [31:0] a);
        instruction = w;
        pc          = a;
        pc_added4   = a + 32'd4;
    endtask

    initial begin
        rst = 1'b0;
        fetch(NOP, 32'h0);
        is_taken = 1'b0; ex_mem_read = 1'b0; ex_dest = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        @(negedge clock);
        check("rst_hazard", 32'(hazard_detected), 32'd0);
        check("rst_halt", 32'(halt_detected), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        rst = 1'b1;

        // ADDI R1,R0,5 then write back R1=5
        fetch(32'h0401_0005, 32'h100);
        tick();
        fetch(NOP, 32'h104);
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        tick();
        wb_en = 1'b0;
        check("addi_valid", 32'(id_valid), 32'd1);
        check("addi_opcode", 32'(id_opcode), 32'h01);
        check("addi_dest", 32'(id_dest), 32'd1);
        check("addi_imm", id_imm, 32'd5);
        check("addi_regwr", 32'(id_reg_write), 32'd1);
        check("addi_memrd", 32'(id_mem_read), 32'd0);
        check("addi_pc", id_pc, 32'h100);
        check("addi_pc4", id_pc_added4, 32'h104);

        // ADD R4,R1,R2 then SUBI R5,R1,-2 back to back
        fetch(32'h0022_2000, 32'h108);
        tick();
        fetch(32'h0C25_FFFE, 32'h10C);
        tick();
        fetch(NOP, 32'h110);
        check("add_rs", id_rs_val, 32'd5);
        check("add_rt", id_rt_val, 32'd0);
        check("add_dest", 32'(id_dest), 32'd4);
        tick();
        check("subi_imm_sext", id_imm, 32'hFFFF_FFFE);
        check("subi_dest", 32'(id_dest), 32'd5);
        check("subi_rs", id_rs_val, 32'd5);

        // Same-cycle write/read of R3 must bypass
        fetch(32'h0060_3000, 32'h120);
        tick();
        fetch(NOP, 32'h124);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5_A5A5;
        tick();
        wb_en = 1'b0;
        check("bypass_rs", id_rs_val, 32'hA5A5_A5A5);
        check("bypass_dest", 32'(id_dest), 32'd6);
        fetch(32'h0063_3800, 32'h128);
        tick();
        fetch(NOP, 32'h12C);
        tick();
        check("r3_rs", id_rs_val, 32'hA5A5_A5A5);
        check("r3_rt", id_rt_val, 32'hA5A5_A5A5);

        // I-type rt is not a source: no hazard on rt match
        fetch(32'h0462_0001, 32'h130);
        tick();
        ex_mem_read = 1'b1; ex_dest = 5'd2;
        #1;
        check("itype_no_hazard", 32'(hazard_detected), 32'd0);
        ex_mem_read = 1'b0; ex_dest = '0;
        fetch(NOP, 32'h134);
        tick();

        // Load-use stall on rs=2: one bubble, then held word issues
        fetch(32'h0041_4000, 32'h200);
        tick();
        ex_mem_read = 1'b1; ex_dest = 5'd2;
        #1;
        check("stall_hazard", 32'(hazard_detected), 32'd1);
        fetch(32'h0409_0007, 32'h204);
        tick();
        ex_mem_read = 1'b0; ex_dest = '0;
        #1;
        check("stall_bubble_valid", 32'(id_valid), 32'd0);
        check("stall_bubble_regwr", 32'(id_reg_write), 32'd0);
        check("stall_hazard_clear", 32'(hazard_detected), 32'd0);
        tick();
        fetch(NOP, 32'h208);
        check("stall_issue_valid", 32'(id_valid), 32'd1);
        check("stall_issue_pc", id_pc, 32'h200);
        check("stall_issue_dest", 32'(id_dest), 32'd8);
        check("stall_issue_rt", id_rt_val, 32'd5);
        tick();
        check("after_stall_pc", id_pc, 32'h204);
        check("after_stall_imm", id_imm, 32'd7);
        check("after_stall_dest", 32'(id_dest), 32'd9);

        // Flush while stalled: bubble, IF/ID invalid, junk word never issues
        fetch(32'h0041_4000, 32'h300);
        tick();
        ex_mem_read = 1'b1; ex_dest = 5'd2;
        #1;
        check("flush_pre_hazard", 32'(hazard_detected), 32'd1);
        is_taken = 1'b1;
        fetch(32'hDEAD_BEEF, 32'h304);
        tick();
        check("flush_hazard", 32'(hazard_detected), 32'd0);
        check("flush_id_valid", 32'(id_valid), 32'd0);
        is_taken = 1'b0; ex_mem_read = 1'b0; ex_dest = '0;
        fetch(NOP, 32'h400);
        tick();
        check("flush_no_issue", 32'(id_valid), 32'd0);
        check("flush_no_opcode", 32'(id_opcode), 32'd0);

        // HALT: sticky flag two edges after fetch, issued once
        fetch(32'h4400_0000, 32'h500);
        tick();
        check("halt_early", 32'(halt_detected), 32'd0);
        fetch(32'h0409_0007, 32'h504);
        tick();
        check("halt_set", 32'(halt_detected), 32'd1);
        check("halt_issue_valid", 32'(id_valid), 32'd1);
        check("halt_issue_op", 32'(id_opcode), 32'h11);
        check("halt_issue_regwr", 32'(id_reg_write), 32'd0);
        tick();
        check("halt_bubble", 32'(id_valid), 32'd0);
        tick();
        check("halt_sticky", 32'(halt_detected), 32'd1);
        check("halt_bubble2", 32'(id_valid), 32'd0);

        // Reset mid-halt
        rst = 1'b0;
        #1;
        check("rst_halt_clear", 32'(halt_detected), 32'd0);
        @(negedge clock);
        rst = 1'b1;

        // Flush beats HALT in IF/ID
        fetch(32'h4400_0000, 32'h600);
        tick();
        is_taken = 1'b1;
        fetch(NOP, 32'h604);
        tick();
        is_taken = 1'b0;
        check("flush_halt_flag", 32'(halt_detected), 32'd0);
        check("flush_halt_valid", 32'(id_valid), 32'd0);
        tick();
        check("flush_halt_flag2", 32'(halt_detected), 32'd0);

        // R1 cleared by reset; R0 write ignored even on bypass path
        fetch(32'h0020_5000, 32'h700);
        tick();
        fetch(NOP, 32'h704);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        wb_en = 1'b0;
        check("r1_after_rst", id_rs_val, 32'd0);
        check("r0_bypass", id_rt_val, 32'd0);
        check("r0_valid", 32'(id_valid), 32'd1);

        // Reset mid-stall with a valid NOP in ID/EX
        fetch(32'h0020_5000, 32'h708);
        tick();
        check("nop_valid", 32'(id_valid), 32'd1);
        check("nop_opcode", 32'(id_opcode), 32'h3F);
        check("nop_regwr", 32'(id_reg_write), 32'd0);
        ex_mem_read = 1'b1; ex_dest = 5'd1;
        #1;
        check("pre_rst_hazard", 32'(hazard_detected), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_hazard", 32'(hazard_detected), 32'd0);
        check("midrst_valid", 32'(id_valid), 32'd0);
        check("midrst_opcode", 32'(id_opcode), 32'd0);
        check("midrst_pc", id_pc, 32'd0);
        @(negedge clock);
        rst = 1'b1;
        ex_mem_read = 1'b0; ex_dest = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have `clock`, input, 1 bit: the single clock, rising edge active.
REQ-002 SHALL have `rst`, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have `instruction`, input, 32 bits: word from fetch.
REQ-004 SHALL have `pc`, input, 32 bits: fetch PC.
REQ-005 SHALL have `pc_added4`, input, 32 bits: fetch PC plus 4.
REQ-006 SHALL have `is_taken`, input, 1 bit: branch resolved taken in EX; flush request.
REQ-007 SHALL have `ex_mem_read`, input, 1 bit, and `ex_dest`, input, 5 bits: load in EX and its destination register.
REQ-008 SHALL have `wb_en`, input, 1 bit; `wb_addr`, input, 5 bits; `wb_data`, input, 32 bits: register-file write port.
REQ-009 SHALL have `hazard_detected`, output, 1 bit: combinational load-use stall to fetch.
REQ-010 SHALL have `halt_detected`, output, 1 bit: registered, sticky HALT seen.
REQ-011 SHALL have these ID/EX register outputs: `id_valid` (1), `id_opcode` (6), `id_rs_val` (32), `id_rt_val` (32), `id_imm` (32), `id_dest` (5), `id_reg_write` (1), `id_mem_read` (1), `id_mem_write` (1), `id_pc` (32), `id_pc_added4` (32).

Function
REQ-012 SHALL decode fields as: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
REQ-013 SHALL decode opcodes 0x00-0x11 as ADD, ADDI, SUB, SUBI, MUL, MULI, OR, ORI, AND, ANDI, XOR, XORI, LDW, STW, BZ, BEQ, JR, HALT.
REQ-014 SHALL treat any other opcode as a NOP: id_reg_write, id_mem_read and id_mem_write all 0.
REQ-015 SHALL set the destination to rd for even opcodes 0x00-0x0A and to rt for odd opcodes 0x01-0x0B and LDW; reg_write 1 for these, else 0.
REQ-016 SHALL use rt as a source for R-type, STW and BEQ only.
REQ-017 SHALL drive id_imm as the sign extension of imm[15:0].
REQ-018 SHALL hold 32x32 registers, with R0 reading 0 and writes to R0 ignored.
REQ-019 SHALL perform the write on the rising edge when wb_en=1.
REQ-020 SHALL bypass reads: a same-cycle read of wb_addr returns wb_data (write-before-read).
REQ-021 SHALL hold an IF/ID register (instr, pc, pc_added4, valid) that loads on each edge unless hazard_detected or halt_detected is 1.
REQ-022 SHALL, when is_taken=1, load IF/ID valid=0 on that edge (flush), with priority over stall.
REQ-023 SHALL assert hazard_detected = IF/ID valid & ex_mem_read & ex_dest!=0 & (ex_dest==rs | (rt-is-source & ex_dest==rt)).
REQ-024 SHALL, when stalling, hold IF/ID and load a bubble into ID/EX (id_valid=0, all control 0).
REQ-025 SHALL load ID/EX with a bubble when is_taken=1, regardless of hazard.
REQ-026 SHALL give a latency of one edge from IF/ID to ID/EX; a fetched word appears on id_* two edges after it is presented.
REQ-027 SHALL, when valid HALT is in IF/ID and not flushed, set halt_detected at that edge and keep it set until reset.
REQ-028 SHALL pass HALT to ID/EX exactly once, followed by bubbles.
REQ-029 SHALL give a flush the same edge precedence over a HALT in IF/ID (HALT discarded, halt_detected stays 0).
REQ-030 SHALL never set id_valid from an IF/ID entry with valid=0, e.g. a 0xDEADBEEF word following a taken branch.

Reset
REQ-031 SHALL, while rst=0, clear asynchronously: IF/ID valid, all ID/EX fields, halt_detected and all 32 registers to 0; hazard_detected therefore reads 0.
REQ-032 SHALL have deassertion take effect at the first rising edge with rst=1; reset mid-stall or mid-halt returns to the empty pipeline.

Verification
REQ-033 SHALL cover: ADDI R1,R0,5 (0x04010005) then WB R1=5 -> id_dest=1, id_imm=5, id_reg_write=1; a later ADD reading R1 gets id_rs_val=5.
REQ-034 SHALL cover: wb_en=1, wb_addr=3, wb_data=0xA5A5A5A5 in the same cycle IF/ID holds a read of R3 -> id_rs_val=0xA5A5A5A5.
REQ-035 SHALL cover: ex_mem_read=1, ex_dest=2, IF/ID ADD with rs=2 -> hazard_detected=1 for one cycle, one bubble, then IF/ID instr unchanged and issued.
REQ-036 SHALL cover: is_taken=1 while hazard_detected=1 -> next edge: IF/ID valid=0, id_valid=0, hazard_detected=0.
REQ-037 SHALL cover: HALT (0x44000000) fetched -> halt_detected=1 two edges later and sticky; id_opcode=0x11 for one cycle, then id_valid=0.
REQ-038 SHALL cover: rst pulsed low mid-operation -> all outputs 0 immediately; writes to R0 read back 0.
